// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
`timescale 1ns/1ps
package nibble_serial_adder_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

endpackage

// File: rtl/nibble_serial_adder_cla4_slice.sv
// 4-bit generate/propagate carry-lookahead slice, purely combinational.
`timescale 1ns/1ps
module cla4_slice
   import nibble_serial_adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                ci,
   output logic [NIBBLE_W-1:0] s,
   output logic                co
);

   logic [NIBBLE_W-1:0] g;
   logic [NIBBLE_W-1:0] p;
   logic [NIBBLE_W-1:0] c;

   // Flattened lookahead carries; no ripple through the slice.
   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
      s    = p ^ c;
   end

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit lookahead slice reused over WIDTH/4 RUN cycles.
// WIDTH must be a multiple of 4 and at least 8.
// Optional subtract mode: define NIBBLE_SERIAL_ADDER_SUB_EN to add the 'sub' port.
`timescale 1ns/1ps
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int unsigned NumNib = WIDTH / NIBBLE_W;
   localparam int unsigned IdxW   = $clog2(NumNib);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NumNib - 1);

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic              carry_q, carry_d;
   logic              cout_q, cout_d;

   logic [NIBBLE_W-1:0] slice_a, slice_b, slice_s;
   logic                slice_co;
   logic                do_sub;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
   assign do_sub = sub;
`else
   assign do_sub = 1'b0;
`endif

   assign slice_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
   assign slice_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

   cla4_slice u_slice (
      .a  (slice_a),
      .b  (slice_b),
      .ci (carry_q),
      .s  (slice_s),
      .co (slice_co)
   );

   // Next-state: capture operands in IDLE, one nibble per RUN cycle, hold in DONE.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = a;
               // Subtract as a + ~b + 1; cin is ignored in that mode.
               b_d     = do_sub ? ~b : b;
               carry_d = do_sub ? 1'b1 : cin;
               idx_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               state_d = StRun;
            end
         end
         StRun: begin
            sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = slice_s;
            carry_d = slice_co;
            idx_d   = idx_q + IdxW'(1);
            if (idx_q == LastIdx) begin
               cout_d  = slice_co;
               idx_d   = '0;
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder (WIDTH=16).
`timescale 1ns/1ps
module tb_nibble_serial_adder;

   localparam int unsigned WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   nibble_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation: transfer, scramble inputs during RUN, optional DONE stall, deliver.
   task automatic do_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input logic vs, input int stall,
                        input logic [15:0] exp_s, input logic exp_c);
      chk({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
      a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
      tick();
      // Inputs changing and in_valid held high while running must not matter.
      a = ~va; b = va ^ vb; cin = ~vc; sub = ~vs;
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) tick();
         chk($sformatf("%s.busy%0d", tag, k), 32'(busy), 32'd1);
         chk($sformatf("%s.in_ready%0d", tag, k), 32'(in_ready), 32'd0);
         if (k < 4) chk($sformatf("%s.out_valid_early%0d", tag, k), 32'(out_valid), 32'd0);
      end
      tick();
      chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".sum"}, 32'(sum), 32'(exp_s));
      chk({tag, ".cout"}, 32'(cout), 32'(exp_c));
      for (int s = 0; s < stall; s++) begin
         in_valid = 1'b1; a = 16'hDEAD; b = 16'hBEEF;
         tick();
         chk($sformatf("%s.stall_valid%0d", tag, s), 32'(out_valid), 32'd1);
         chk($sformatf("%s.stall_ready%0d", tag, s), 32'(in_ready), 32'd0);
         chk($sformatf("%s.stall_sum%0d", tag, s), 32'(sum), 32'(exp_s));
         chk($sformatf("%s.stall_cout%0d", tag, s), 32'(cout), 32'(exp_c));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, ".delivered_valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".delivered_ready"}, 32'(in_ready), 32'd1);
      chk({tag, ".delivered_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = 16'h0; b = 16'h0; cin = 1'b0; sub = 1'b0;
      tick();
      tick();
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.sum", 32'(sum), 32'd0);
      chk("rst.cout", 32'(cout), 32'd0);
      rst_n = 1'b1;
      tick();

      do_op("add_5555", 16'h1234, 16'h4321, 1'b0, 1'b0, 0, 16'h5555, 1'b0);
      do_op("ripple_b1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1);
      do_op("ripple_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 16'h0000, 1'b1);
      do_op("msb_carry", 16'h8000, 16'h8000, 1'b0, 1'b0, 0, 16'h0000, 1'b1);
      do_op("mixed", 16'hABCD, 16'h1234, 1'b1, 1'b0, 0, 16'hBE02, 1'b0);
      do_op("stall", 16'h0F0F, 16'h0101, 1'b1, 1'b0, 3, 16'h1011, 1'b0);

      // Abort mid-operation with reset.
      a = 16'h5A5A; b = 16'hA5A5; cin = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("abort.in_ready", 32'(in_ready), 32'd1);
      chk("abort.out_valid", 32'(out_valid), 32'd0);
      chk("abort.busy", 32'(busy), 32'd0);
      chk("abort.sum", 32'(sum), 32'd0);
      chk("abort.cout", 32'(cout), 32'd0);
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("abort.post_valid%0d", k), 32'(out_valid), 32'd0);
         chk($sformatf("abort.post_ready%0d", k), 32'(in_ready), 32'd1);
      end
      do_op("after_abort", 16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 16'h0100, 1'b0);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      do_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 0, 16'hFFFE, 1'b0);
      do_op("sub_pos", 16'h0007, 16'h0005, 1'b1, 1'b1, 0, 16'h0002, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port in_valid  input  1  operand set presented.
REQ-005 Port in_ready  output  1  block can accept an operand set.
REQ-006 Port a  input  WIDTH  operand A.
REQ-007 Port b  input  WIDTH  operand B.
REQ-008 Port cin  input  1  carry into nibble 0.
REQ-009 Port out_valid  output  1  result available.
REQ-010 Port out_ready  input  1  downstream accepts the result.
REQ-011 Port sum  output  WIDTH  result, a+b+cin mod 2^WIDTH.
REQ-012 Port cout  output  1  carry out of the top nibble.
REQ-013 Port busy  output  1  high in RUN or DONE.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; a transfer occurs on a rising edge with in_valid=1 and in_ready=1.
REQ-016 On transfer: a, b and cin are registered, nibble index cleared to 0, carry register loaded with cin, and the FSM goes to RUN.
REQ-017 Each RUN cycle: nibble idx of registered a and b plus the carry register feeds one 4-bit lookahead slice; the slice sum is written to sum[4*idx+3:4*idx], the slice carry to the carry register, and idx increments.
REQ-018 After nibble WIDTH/4-1 is written, the FSM SHALL enter DONE with cout equal to the final carry.
REQ-019 Latency: out_valid SHALL rise exactly WIDTH/4 clock edges after the transfer edge (4 for WIDTH=16).
REQ-020 In DONE, out_valid=1 and sum/cout SHALL hold stable until a rising edge with out_ready=1, at which the FSM returns to IDLE and out_valid falls.
REQ-021 in_valid SHALL be ignored outside IDLE; a, b and cin changing during RUN SHALL NOT affect the result.
REQ-022 Throughput: at most one operation per WIDTH/4+2 cycles; no overlap of accept and deliver.
REQ-023 Carry SHALL propagate across every nibble boundary, including a full-width ripple (all nibbles propagating).

Reset
REQ-024 While rst_n=0: state IDLE, in_ready 1, out_valid 0, busy 0, sum 0, cout 0, idx 0, carry register 0.
REQ-025 Reset asserted in RUN or DONE SHALL abort the operation with no result delivered; the first transfer after release SHALL compute correctly.

Configuration
REQ-026 Macro NIBBLE_SERIAL_ADDER_SUB_EN: when defined, add port sub  input  1, sampled at transfer; sub=1 SHALL compute a + ~b + 1 (cin ignored), with cout=1 meaning no borrow.
REQ-027 Without NIBBLE_SERIAL_ADDER_SUB_EN, the sub port SHALL NOT exist and the block SHALL always add.

Structure
REQ-028 Package nibble_serial_adder_pkg SHALL hold the FSM state enum typedef and constant NIBBLE_W=4.
REQ-029 One combinational sub-module cla4_slice (4-bit generate/propagate lookahead: a, b, ci -> s, co) SHALL be instantiated once and reused every RUN cycle.

Verification (WIDTH=16)
REQ-030 a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, out_valid 4 edges after transfer.
REQ-031 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry through all nibbles).
REQ-032 a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1; a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1.
REQ-033 out_ready held 0 for 3 cycles in DONE -> sum/cout stable, in_ready=0, in_valid pulses ignored; result delivered on the first out_ready=1 edge.
REQ-034 rst_n pulsed low after 2 RUN cycles -> out_valid stays 0 and in_ready=1 after release; next op 0x00FF+0x0001 -> sum=0x0100, cout=0.
REQ-035 With NIBBLE_SERIAL_ADDER_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
